// File: rtl/sha_pkg.sv
// Shared constants and types for the SHA message-schedule blocks.
package sha_pkg;

    localparam logic SHA_MODE_SHA1 = 1'b0;
    localparam logic SHA_MODE_SHA2 = 1'b1;

    localparam int SHA1_ROUNDS   = 80;
    localparam int SHA256_ROUNDS = 64;
    localparam int SHA512_ROUNDS = 80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } sched_state_t;

    // Small-sigma rotate/shift amounts: s0 = rotr R0 ^ rotr R1 ^ shr SH, same for s1.
    localparam int S256_S0_R0 = 7;
    localparam int S256_S0_R1 = 18;
    localparam int S256_S0_SH = 3;
    localparam int S256_S1_R0 = 17;
    localparam int S256_S1_R1 = 19;
    localparam int S256_S1_SH = 10;

    localparam int S512_S0_R0 = 1;
    localparam int S512_S0_R1 = 8;
    localparam int S512_S0_SH = 7;
    localparam int S512_S1_R0 = 19;
    localparam int S512_S1_R1 = 61;
    localparam int S512_S1_SH = 6;

endpackage

// File: rtl/sha_sched_next.sv
// Combinational next schedule word from the 16-word sliding window (window[0] = W_t).
module sha_sched_next
    import sha_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              mode,
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w2,
    input  logic [WORD_W-1:0] w8,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w13,
    input  logic [WORD_W-1:0] w14,
    output logic [WORD_W-1:0] nxt
);

    localparam bit WIDE  = (WORD_W == 64);
    localparam int S0_R0 = WIDE ? S512_S0_R0 : S256_S0_R0;
    localparam int S0_R1 = WIDE ? S512_S0_R1 : S256_S0_R1;
    localparam int S0_SH = WIDE ? S512_S0_SH : S256_S0_SH;
    localparam int S1_R0 = WIDE ? S512_S1_R0 : S256_S1_R0;
    localparam int S1_R1 = WIDE ? S512_S1_R1 : S256_S1_R1;
    localparam int S1_SH = WIDE ? S512_S1_SH : S256_S1_SH;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    logic [WORD_W-1:0] s0, s1, sha1_x;

    assign s0     = rotr(w1, S0_R0) ^ rotr(w1, S0_R1) ^ (w1 >> S0_SH);
    assign s1     = rotr(w14, S1_R0) ^ rotr(w14, S1_R1) ^ (w14 >> S1_SH);
    assign sha1_x = w13 ^ w8 ^ w2 ^ w0;

    assign nxt = (mode == SHA_MODE_SHA1) ? {sha1_x[WORD_W-2:0], sha1_x[WORD_W-1]}
                                         : s1 + w9 + s0 + w0;

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-1/SHA-2 message schedule: loads 16 words, then streams W_0..W_{N-1}.
module sha_msg_schedule
    import sha_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              done,
    output logic              err
);

    localparam logic [IDX_W-1:0] LAST_SHA1   = IDX_W'(SHA1_ROUNDS - 1);
    localparam logic [IDX_W-1:0] LAST_SHA256 = IDX_W'(SHA256_ROUNDS - 1);
    localparam logic [IDX_W-1:0] LAST_SHA512 = IDX_W'(SHA512_ROUNDS - 1);

    sched_state_t      state, state_nxt;
    logic [WORD_W-1:0] window [16];
    logic [3:0]        load_cnt;
    logic [IDX_W-1:0]  t;
    logic              mode_q;
    logic              in_hs, out_hs, start_ok, start_bad, last;
    logic [WORD_W-1:0] nxt;

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == EMIT);
    assign out_data  = window[0];
    assign out_idx   = t;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    // The 64-bit build only implements SHA-512, so a SHA-1 request is refused.
    assign start_bad = (state == IDLE) && start && (WORD_W == 64) && (mode == SHA_MODE_SHA1);
    assign start_ok  = (state == IDLE) && start && !start_bad;

    assign last = (t == ((WORD_W == 64)               ? LAST_SHA512 :
                         (mode_q == SHA_MODE_SHA1)    ? LAST_SHA1   : LAST_SHA256));

    sha_sched_next #(.WORD_W(WORD_W)) u_next (
        .mode (mode_q),
        .w0   (window[0]),
        .w1   (window[1]),
        .w2   (window[2]),
        .w8   (window[8]),
        .w9   (window[9]),
        .w13  (window[13]),
        .w14  (window[14]),
        .nxt  (nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_nxt = LOAD;
                LOAD:    if (in_hs && load_cnt == 4'd15) state_nxt = EMIT;
                EMIT:    if (out_hs && last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) window[i] <= '0;
            load_cnt <= '0;
            t        <= '0;
            mode_q   <= SHA_MODE_SHA1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                load_cnt <= '0;
                t        <= '0;
                err      <= 1'b0;
            end else begin
                if (start_bad) err <= 1'b1;
                if (start_ok) begin
                    err      <= 1'b0;
                    mode_q   <= mode;
                    load_cnt <= '0;
                    t        <= '0;
                end
                if (in_hs) begin
                    window[load_cnt] <= in_data;
                    load_cnt         <= load_cnt + 4'd1;
                end
                // Window slides only on a consumed word, so a stall freezes everything.
                if (out_hs) begin
                    for (int i = 0; i < 15; i++) window[i] <= window[i+1];
                    window[15] <= nxt;
                    t          <= last ? '0 : t + 1'b1;
                    done       <= last;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule (32-bit SHA-1/SHA-256 plus a 64-bit instance).
module tb_sha_msg_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, mode, abort, in_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic        in_ready, out_valid, done, err;
    logic [6:0]  out_idx;

    logic        start_w, mode_w, abort_w, in_valid_w, out_ready_w;
    logic [63:0] in_data_w, out_data_w;
    logic        in_ready_w, out_valid_w, done_w, err_w;
    logic [6:0]  out_idx_w;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] blk [16];
    logic [31:0] exp_w [80];
    logic [31:0] got_w [80];

    sha_msg_schedule #(.WORD_W(32), .IDX_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .done(done), .err(err)
    );

    sha_msg_schedule #(.WORD_W(64), .IDX_W(7)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start_w), .mode(mode_w), .abort(abort_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .in_data(in_data_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
        .out_idx(out_idx_w), .done(done_w), .err(err_w)
    );

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule in textbook W[t-k] form.
    task automatic build_exp(input logic m);
        logic [31:0] x, a, b;
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
        for (int i = 16; i < 80; i++) begin
            if (!m) begin
                x = exp_w[i-3] ^ exp_w[i-8] ^ exp_w[i-14] ^ exp_w[i-16];
                exp_w[i] = {x[30:0], x[31]};
            end else begin
                a = rotr32(exp_w[i-2], 17) ^ rotr32(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
                b = rotr32(exp_w[i-15], 7) ^ rotr32(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
                exp_w[i] = a + exp_w[i-7] + b + exp_w[i-16];
            end
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1; mode = m;
        @(negedge clk);
        start = 1'b0; mode = ~m;
    endtask

    task automatic feed(input int gap, output logic pre_valid);
        int tmo;
        pre_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gap; g++) begin in_valid = 1'b0; @(negedge clk); end
            in_valid = 1'b1; in_data = blk[i];
            tmo = 0;
            while (!in_ready && tmo < 50) begin @(negedge clk); tmo++; end
            if (i == 15) pre_valid = out_valid;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int nexp, input bit bp, output int n, output int idx_bad,
                           output int hold_bad);
        int tmo; bit stalled; logic [31:0] hd; logic [6:0] hi;
        n = 0; idx_bad = 0; hold_bad = 0; tmo = 0; stalled = 1'b0; hd = '0; hi = '0;
        while (n < nexp && tmo < 1000) begin
            if (stalled && out_valid && (out_data !== hd || out_idx !== hi)) hold_bad++;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = out_valid && !out_ready; hd = out_data; hi = out_idx;
            if (out_valid && out_ready) begin
                if (out_idx !== 7'(n)) idx_bad++;
                got_w[n] = out_data;
                n++;
            end
            @(negedge clk); tmo++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({in_ready, out_valid, done, err} !== 4'b0) begin failures++;
            $display("FAIL reset_flags: got %b required 0000", {in_ready, out_valid, done, err}); end
        checks++; if (out_data !== 32'h0 || out_idx !== 7'h0) begin failures++;
            $display("FAIL reset_data: got %h/%0d required 0/0", out_data, out_idx); end
        checks++; if (err_w !== 1'b0 || out_valid_w !== 1'b0) begin failures++;
            $display("FAIL reset_64: err=%b valid=%b required 0 0", err_w, out_valid_w); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sha1_abc();
        int t0, n, ib, hb, bad; logic pv;
        set_abc(); build_exp(1'b0);
        t0 = cyc;
        do_start(1'b0);
        feed(0, pv);
        checks++; if (out_valid !== 1'b1 || out_idx !== 7'd0 || out_data !== 32'h61626380) begin
            failures++; $display("FAIL sha1_first: valid=%b idx=%0d data=%h required 1 0 61626380",
                                 out_valid, out_idx, out_data); end
        collect(80, 1'b0, n, ib, hb);
        checks++; if (n !== 80 || ib !== 0) begin failures++;
            $display("FAIL sha1_count: words=%0d idx_errs=%0d required 80 0", n, ib); end
        checks++; if (got_w[16] !== 32'hC2C4C700 || got_w[18] !== 32'h00000030) begin failures++;
            $display("FAIL sha1_w16: got %h %h required c2c4c700 00000030", got_w[16], got_w[18]); end
        bad = 0; for (int i = 0; i < 80; i++) if (got_w[i] !== exp_w[i]) bad++;
        checks++; if (bad !== 0) begin failures++;
            $display("FAIL sha1_seq: %0d wrong words required 0", bad); end
        checks++; if (done !== 1'b1 || cyc - t0 !== 97) begin failures++;
            $display("FAIL sha1_done: done=%b cycles=%0d required 1 97", done, cyc - t0); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin failures++;
            $display("FAIL sha1_done_pulse: done=%b valid=%b required 0 0", done, out_valid); end
    endtask

    task automatic test_sha256_abc();
        int n, ib, hb, bad; logic pv;
        set_abc(); build_exp(1'b1);
        do_start(1'b1);
        feed(0, pv);
        collect(64, 1'b0, n, ib, hb);
        checks++; if (n !== 64 || ib !== 0) begin failures++;
            $display("FAIL sha256_count: words=%0d idx_errs=%0d required 64 0", n, ib); end
        checks++; if (got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000) begin failures++;
            $display("FAIL sha256_w16: got %h %h required 61626380 000f0000", got_w[16], got_w[17]); end
        bad = 0; for (int i = 0; i < 64; i++) if (got_w[i] !== exp_w[i]) bad++;
        checks++; if (bad !== 0) begin failures++;
            $display("FAIL sha256_seq: %0d wrong words required 0", bad); end
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin failures++;
            $display("FAIL sha256_done: done=%b valid=%b required 1 0", done, out_valid); end
        // start coinciding with done is accepted
        do_start(1'b1);
        checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin failures++;
            $display("FAIL start_on_done: in_ready=%b done=%b required 1 0", in_ready, done); end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++;
            $display("FAIL abort_load: in_ready=%b required 0", in_ready); end
    endtask

    task automatic test_backpressure();
        int n, ib, hb, bad; logic pv;
        set_abc(); build_exp(1'b0);
        do_start(1'b0);
        feed(0, pv);
        collect(80, 1'b1, n, ib, hb);
        checks++; if (n !== 80 || ib !== 0 || hb !== 0) begin failures++;
            $display("FAIL bp_flow: words=%0d idx_errs=%0d hold_errs=%0d required 80 0 0", n, ib, hb); end
        bad = 0; for (int i = 0; i < 80; i++) if (got_w[i] !== exp_w[i]) bad++;
        checks++; if (bad !== 0) begin failures++;
            $display("FAIL bp_seq: %0d wrong words required 0", bad); end
        checks++; if (done !== 1'b1) begin failures++;
            $display("FAIL bp_done: done=%b required 1", done); end
        @(negedge clk);
    endtask

    task automatic test_gapped_load();
        int n, ib, hb, bad; logic pv;
        for (int i = 0; i < 16; i++) blk[i] = 32'h01020304 * (i + 1) ^ 32'hA5A50000;
        build_exp(1'b1);
        do_start(1'b1);
        feed(2, pv);
        checks++; if (pv !== 1'b0 || out_valid !== 1'b1) begin failures++;
            $display("FAIL gap_first_valid: before=%b after=%b required 0 1", pv, out_valid); end
        collect(64, 1'b0, n, ib, hb);
        bad = 0; for (int i = 0; i < 16; i++) if (got_w[i] !== blk[i]) bad++;
        checks++; if (n !== 64 || bad !== 0) begin failures++;
            $display("FAIL gap_echo: words=%0d bad_echo=%0d required 64 0", n, bad); end
        bad = 0; for (int i = 16; i < 64; i++) if (got_w[i] !== exp_w[i]) bad++;
        checks++; if (bad !== 0) begin failures++;
            $display("FAIL gap_seq: %0d wrong words required 0", bad); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int n, ib, hb, bad, dseen; logic pv;
        set_abc();
        do_start(1'b0);
        feed(0, pv);
        collect(40, 1'b0, n, ib, hb);
        checks++; if (out_idx !== 7'd40 || out_valid !== 1'b1) begin failures++;
            $display("FAIL abort_pos: idx=%0d valid=%b required 40 1", out_idx, out_valid); end
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || out_idx !== 7'd0) begin
            failures++; $display("FAIL abort_clear: valid=%b ready=%b done=%b idx=%0d required 0 0 0 0",
                                 out_valid, in_ready, done, out_idx); end
        for (int i = 0; i < 16; i++) blk[i] = 32'h10000000 + i * 32'h00010001;
        build_exp(1'b0);
        dseen = 0;
        do_start(1'b0);
        if (done) dseen++;
        feed(0, pv);
        collect(80, 1'b0, n, ib, hb);
        checks++; if (dseen !== 0 || got_w[0] !== 32'h10000000 || ib !== 0) begin failures++;
            $display("FAIL abort_restart: done_seen=%0d w0=%h idx_errs=%0d required 0 10000000 0",
                     dseen, got_w[0], ib); end
        bad = 0; for (int i = 0; i < 80; i++) if (got_w[i] !== exp_w[i]) bad++;
        checks++; if (n !== 80 || bad !== 0 || done !== 1'b1) begin failures++;
            $display("FAIL abort_newblk: words=%0d bad=%0d done=%b required 80 0 1", n, bad, done); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int n, ib, hb, bad; logic pv;
        set_abc();
        do_start(1'b0);
        for (int i = 0; i < 5; i++) begin in_valid = 1'b1; in_data = 32'hDEAD0000 + i; @(negedge clk); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid); end
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        build_exp(1'b1);
        do_start(1'b1);
        feed(0, pv);
        collect(64, 1'b0, n, ib, hb);
        bad = 0; for (int i = 0; i < 64; i++) if (got_w[i] !== exp_w[i]) bad++;
        checks++; if (n !== 64 || ib !== 0 || bad !== 0 || done !== 1'b1) begin failures++;
            $display("FAIL post_reset_blk: words=%0d idx_errs=%0d bad=%0d done=%b required 64 0 0 1",
                     n, ib, bad, done); end
        @(negedge clk);
    endtask

    task automatic test_err64();
        start_w = 1'b1; mode_w = 1'b0; @(negedge clk); start_w = 1'b0;
        checks++; if (err_w !== 1'b1 || in_ready_w !== 1'b0) begin failures++;
            $display("FAIL err64_set: err=%b in_ready=%b required 1 0", err_w, in_ready_w); end
        @(negedge clk);
        checks++; if (err_w !== 1'b1) begin failures++;
            $display("FAIL err64_sticky: err=%b required 1", err_w); end
        start_w = 1'b1; mode_w = 1'b1; @(negedge clk); start_w = 1'b0;
        checks++; if (err_w !== 1'b0 || in_ready_w !== 1'b1) begin failures++;
            $display("FAIL err64_clear: err=%b in_ready=%b required 0 1", err_w, in_ready_w); end
        for (int i = 0; i < 16; i++) begin
            in_valid_w = 1'b1;
            in_data_w  = (i == 0) ? 64'h1 : (i == 1) ? 64'h8000000000000000 : 64'h0;
            @(negedge clk);
        end
        in_valid_w = 1'b0; out_ready_w = 1'b1;
        repeat (16) @(negedge clk);
        checks++; if (out_idx_w !== 7'd16 || out_data_w !== 64'h4180000000000001) begin failures++;
            $display("FAIL sha512_w16: idx=%0d data=%h required 16 4180000000000001", out_idx_w, out_data_w); end
        @(negedge clk);
        checks++; if (out_data_w !== 64'h8000000000000000) begin failures++;
            $display("FAIL sha512_w17: data=%h required 8000000000000000", out_data_w); end
        abort_w = 1'b1; @(negedge clk); abort_w = 1'b0; out_ready_w = 1'b0;
        start_w = 1'b1; mode_w = 1'b0; @(negedge clk); start_w = 1'b0;
        abort_w = 1'b1; @(negedge clk); abort_w = 1'b0;
        checks++; if (err_w !== 1'b0 || out_valid_w !== 1'b0 || done_w !== 1'b0) begin failures++;
            $display("FAIL err64_abort: err=%b valid=%b done=%b required 0 0 0", err_w, out_valid_w, done_w); end
    endtask

    initial begin
        start = 0; mode = 0; abort = 0; in_valid = 0; out_ready = 0; in_data = '0;
        start_w = 0; mode_w = 0; abort_w = 0; in_valid_w = 0; out_ready_w = 0; in_data_w = '0;
        test_reset();
        test_sha1_abc();
        test_sha256_abc();
        test_backpressure();
        test_gapped_load();
        test_abort();
        test_async_reset();
        test_err64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha_msg_schedule.md
Name: sha_msg_schedule

Overview:
Parametrised SHA message-schedule generator; successor to the fixed SHA-1 W_t shift register. Accepts one 512/1024-bit block as 16 words over a valid/ready input stream. Emits W_0..W_{N-1} over a valid/ready output stream to the compression core. Mode (SHA-1 / SHA-2) is selected per block; the sliding 16-word window expands the schedule on the fly.

Parameters:
WORD_W, 32, word width; 32 gives SHA-1/SHA-256, 64 gives SHA-512 (mode 1 only)
IDX_W, 7, width of the round index output

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin new block; honoured only in IDLE
mode  in  1  0=SHA-1, 1=SHA-2; sampled with start
abort  in  1  synchronous clear to IDLE, any state
in_valid  in  1  input word valid
in_ready  out  1  block accepts input word
in_data  in  WORD_W  message word, big-endian word order W_0 first
out_valid  out  1  W_t available
out_ready  in  1  consumer takes W_t
out_data  out  WORD_W  W_t
out_idx  out  IDX_W  t of current out_data
done  out  1  one-cycle pulse after W_{N-1} handshake
err  out  1  sticky; start with mode=0 while WORD_W=64; cleared by next legal start or abort

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; window, counters, out_data, out_idx = 0; in_ready, out_valid, done, err = 0.
- State machine: IDLE -> LOAD on start (illegal mode: set err, stay IDLE). LOAD -> EMIT on the 16th input handshake. EMIT -> IDLE on handshake with out_idx=N-1; done=1 the following cycle only.
- N = 80 for SHA-1 and for WORD_W=64; N = 64 for SHA-256. mode is latched at start; changes on the mode pin afterwards are ignored.
- LOAD: in_ready=1. Each in_valid&in_ready writes in_data to window[load_cnt], load_cnt 0..15. out_valid=0.
- EMIT: out_valid=1, out_data=window[0], out_idx=t. The first out_valid is asserted the cycle after the 16th input handshake.
- On each out handshake: window shifts down one (window[i] <= window[i+1]); t increments. window[15] receives the new word computed from the pre-shift window:
  - SHA-1: rotl1(window[13]^window[8]^window[2]^window[0]).
  - SHA-256: s1(window[14])+window[9]+s0(window[1])+window[0], mod 2^32. s0 = rotr7^rotr18^shr3; s1 = rotr17^rotr19^shr10.
  - SHA-512: same form, mod 2^64. s0 = rotr1^rotr8^shr7; s1 = rotr19^rotr61^shr6.
  - Computed words for t+16 >= N are don't-care and are never emitted.
- out_valid held with out_ready=0: out_data and out_idx stay stable, window is frozen.
- start during LOAD/EMIT: ignored. start in the same cycle as done: accepted (already IDLE).
- abort: next cycle state=IDLE, in_ready=0, out_valid=0, counters=0, no done pulse. abort wins over start and over any handshake in the same cycle.
- rst_n asserted mid-block: all state cleared immediately; no output is produced for the partial block.
- Throughput: one W_t per cycle with out_ready held high. A full SHA-1 block takes 16+80 cycles plus one done cycle.

Decomposition:
- Shared package sha_pkg: mode encodings (SHA_MODE_SHA1=0, SHA_MODE_SHA2=1), round counts (SHA1_ROUNDS=80, SHA256_ROUNDS=64, SHA512_ROUNDS=80), FSM state typedef (IDLE/LOAD/EMIT), sigma rotate/shift constants per word width.
- One sub-module sha_sched_next: combinational next-word function. Inputs window[0],[1],[2],[8],[9],[13],[14] and mode, parametrised by WORD_W. Reused by the unrolled core later.

Test Plan:
- SHA-1 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 -> W16=0xC2C4C700, out_idx runs 0..79, done one cycle after idx 79, 97 cycles start-to-done.
- SHA-256 "abc" block, mode=1 -> W16=0x61626380, W17=0x000F0000, last out_idx=63, done after 64 emits.
- Random out_ready backpressure (~50%) on SHA-1 "abc" -> word sequence identical to no-backpressure run; out_data stable while out_valid&!out_ready.
- Gaps in in_valid during LOAD (valid every 3rd cycle) -> W0..W15 echoed in order; first out_valid exactly one cycle after 16th accept.
- abort asserted at out_idx=40, then immediate start with a new block -> no done for the aborted block; new block's W0 emitted correctly at out_idx=0.
- rst_n pulsed low asynchronously mid-LOAD -> in_ready=0 and out_valid=0 without waiting for a clk edge; next start behaves as a fresh block. For WORD_W=64 with mode=0 start -> err=1, state stays IDLE.
